// File: rtl/nf_dm_bridge.sv
// CPU data-port to valid/ready slave bridge with alignment check, bus timeout and a held read-data register.
// Latency 2 + slave waits (misaligned 1, timeout TIMEOUT+1); req_dm is held until req_ack_dm, and a stalled slave is cut off by the timeout.
module nf_dm_bridge #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_dm,
  input  logic [31:0] wd_dm,
  input  logic        we_dm,
  input  logic        req_dm,
  output logic        req_ack_dm,
  output logic [31:0] rd_dm,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wd,
  output logic        bus_we,
  output logic        bus_valid,
  input  logic        bus_ready,
  input  logic [31:0] bus_rd,
  output logic        err,
  output logic        err_sticky,
  input  logic        err_clr
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wd;
  logic        r_bus_we;
  logic [31:0] r_rd;
  logic [7:0]  r_cnt;
  logic        r_err_pend;
  logic        r_err_sticky;

  logic        w_latch;
  logic        w_cnt_inc;
  logic        w_set_pend;
  logic        w_rd_load;
  logic [31:0] w_rd_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_cnt_inc  = 1'b0;
    w_set_pend = 1'b0;
    w_rd_load  = 1'b0;
    w_rd_val   = bus_rd;
    case (r_state)
      S_IDLE: begin
        if (req_dm) begin
          if (addr_dm[1:0] == 2'b00) begin
            w_latch = 1'b1;
            w_next  = S_REQ;
          end else begin
            w_set_pend = 1'b1;
            w_rd_load  = ~we_dm;
            w_rd_val   = ERR_DATA;
            w_next     = S_ACK;
          end
        end
      end
      S_REQ: begin
        if (bus_ready) begin
          w_rd_load = ~r_bus_we;
          w_next    = S_ACK;
        end else if (r_cnt == TO_LAST) begin
          w_set_pend = 1'b1;
          w_rd_load  = ~r_bus_we;
          w_rd_val   = ERR_DATA;
          w_next     = S_ACK;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are only loaded from IDLE, so they stay stable for all of REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_addr <= '0;
      r_bus_wd   <= '0;
      r_bus_we   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_latch) begin
        r_bus_addr <= addr_dm;
        r_bus_wd   <= wd_dm;
        r_bus_we   <= we_dm;
        r_cnt      <= '0;
      end else if (w_cnt_inc && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_rd <= '0;
    else if (w_rd_load) r_rd <= w_rd_val;
  end

  // A new error outranks err_clr on the sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_pend   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_set_pend)             r_err_pend <= 1'b1;
      else if (r_state == S_ACK)  r_err_pend <= 1'b0;
      if (r_state == S_ACK && r_err_pend) r_err_sticky <= 1'b1;
      else if (err_clr)                   r_err_sticky <= 1'b0;
    end
  end

  assign req_ack_dm = (r_state == S_ACK);
  assign err        = (r_state == S_ACK) && r_err_pend;
  assign err_sticky = r_err_sticky;
  assign bus_valid  = (r_state == S_REQ);
  assign bus_addr   = r_bus_addr;
  assign bus_wd     = r_bus_wd;
  assign bus_we     = r_bus_we;
  assign rd_dm      = r_rd;

endmodule

// File: tb/tb_nf_dm_bridge.sv
// Transaction-level bench for nf_dm_bridge: directed scenarios plus randomized traffic against a reference model.
module tb_nf_dm_bridge;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_dm = '0;
  logic [31:0] wd_dm = '0;
  logic        we_dm = 1'b0;
  logic        req_dm = 1'b0;
  logic        req_ack_dm;
  logic [31:0] rd_dm;
  logic [31:0] bus_addr;
  logic [31:0] bus_wd;
  logic        bus_we;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rd = '0;
  logic        err;
  logic        err_sticky;
  logic        err_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] m_rd = '0;
  logic        m_sticky = 1'b0;

  nf_dm_bridge #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .reset(reset),
    .addr_dm(addr_dm), .wd_dm(wd_dm), .we_dm(we_dm), .req_dm(req_dm),
    .req_ack_dm(req_ack_dm), .rd_dm(rd_dm),
    .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_we(bus_we),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_rd(bus_rd),
    .err(err), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advances one cycle, issues one CPU request and plays a slave that answers
  // on its (waits+1)-th valid cycle, or never when stuck.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input int waits, input logic stuck, input logic [31:0] rdata,
                        output int ack_cyc);
    int c, nv, bad, exp_lat, exp_vld;
    logic got_ack, got_err, misal, tmo, exp_err;
    logic [31:0] rd_at_ack;
    step();
    chk("rd_hold", rd_dm, m_rd);
    chk("sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    addr_dm = a; wd_dm = wd; we_dm = we; req_dm = 1'b1;
    c = 0; nv = 0; bad = 0; got_ack = 1'b0; got_err = 1'b0; rd_at_ack = '0; ack_cyc = -1;
    while (!got_ack && c < 100) begin
      if (req_ack_dm) begin
        got_ack = 1'b1;
        got_err = err;
        rd_at_ack = rd_dm;
        ack_cyc = cyc;
        if (bus_valid) bad++;
        req_dm = 1'b0;
        bus_ready = 1'b0;
      end else begin
        if (err) bad++;
        if (bus_valid) begin
          nv++;
          if (bus_addr !== a || bus_wd !== wd || bus_we !== we) bad++;
          if (!stuck && nv > waits) begin
            bus_ready = 1'b1;
            bus_rd = rdata;
          end else begin
            bus_ready = 1'b0;
            bus_rd = $urandom;
          end
        end else begin
          bus_ready = 1'($urandom_range(0, 1));
          bus_rd = $urandom;
        end
        step();
        c++;
      end
    end
    req_dm = 1'b0;
    misal   = (a[1:0] != 2'b00);
    tmo     = !misal && stuck;
    exp_err = misal || tmo;
    exp_lat = misal ? 1 : (tmo ? TIMEOUT + 1 : waits + 2);
    exp_vld = misal ? 0 : (tmo ? TIMEOUT : waits + 1);
    if (!we) m_rd = exp_err ? ERR_DATA : rdata;
    if (exp_err) m_sticky = 1'b1;
    chk("ack_latency", c, exp_lat);
    chk("err", {31'd0, got_err}, {31'd0, exp_err});
    chk("valid_cycles", nv, exp_vld);
    chk("bus_stable", bad, 0);
    chk("rd_at_ack", rd_at_ack, m_rd);
  endtask

  initial begin
    int t0, t1, t2, dummy;
    logic [31:0] a;
    @(negedge clk);
    step();
    chk("rst_ack", {31'd0, req_ack_dm}, 32'd0);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_rd", rd_dm, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wd", bus_wd, 32'd0);
    reset = 1'b0;

    do_txn(32'h0000_0010, 32'h0, 1'b0, 0, 1'b0, 32'h1234_5678, dummy);
    do_txn(32'h0000_0020, 32'hA5A5_A5A5, 1'b1, 3, 1'b0, 32'h5555_0000, dummy);
    do_txn(32'h0000_0030, 32'h0, 1'b0, 0, 1'b1, 32'h0BAD_0BAD, dummy);
    do_txn(32'h0000_0013, 32'h0, 1'b0, 0, 1'b0, 32'h7777_7777, dummy);

    step();
    chk("sticky_before_clr", {31'd0, err_sticky}, {31'd0, m_sticky});
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_sticky = 1'b0;
    chk("sticky_after_clr", {31'd0, err_sticky}, 32'd0);

    do_txn(32'h0000_0040, 32'h0, 1'b0, 0, 1'b0, 32'h4040_4040, t0);
    do_txn(32'h0000_0044, 32'hCAFE_0044, 1'b1, 0, 1'b0, 32'h4444_4444, t1);
    do_txn(32'h0000_0048, 32'h0, 1'b0, 0, 1'b0, 32'h4848_4848, t2);
    chk("b2b_gap1", t1 - t0, 3);
    chk("b2b_gap2", t2 - t1, 3);

    // Abort a read during a wait state
    step();
    addr_dm = 32'h100; we_dm = 1'b0; req_dm = 1'b1; bus_ready = 1'b0;
    step(); step(); step();
    chk("pre_reset_valid", {31'd0, bus_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_valid", {31'd0, bus_valid}, 32'd0);
    chk("mid_reset_ack", {31'd0, req_ack_dm}, 32'd0);
    chk("mid_reset_rd", rd_dm, 32'd0);
    req_dm = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_rd = '0;
    m_sticky = 1'b0;
    do_txn(32'h0000_0200, 32'h0, 1'b0, 2, 1'b0, 32'h0220_0220, dummy);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      do_txn(a, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
             ($urandom_range(0, 9) == 0), $urandom, dummy);
    end
    step();
    chk("final_rd_hold", rd_dm, m_rd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
